// File: rtl/ram_rf_port_if.sv
// Bundle of register-file request signals, clear control and RAM port signals.
interface ram_rf_port_if #(
    parameter int unsigned DATASIZE = 18,
    parameter int unsigned ADDRSIZE = 8
);
    logic [ADDRSIZE-1:0] rf_address;
    logic                rf_read_en;
    logic                rf_write_en;
    logic [DATASIZE-1:0] rf_write_data;
    logic [DATASIZE-1:0] rf_read_data;
    logic                rf_done;
    logic                rf_access_err;
    logic                clear_start;
    logic                clear_busy;
    logic                ram_wen;
    logic                ram_ren;
    logic [ADDRSIZE-1:0] ram_addr;
    logic [DATASIZE-1:0] ram_wdata;
    logic [DATASIZE-1:0] ram_rdata;

    // Controller side.
    modport slave (
        input  rf_address, rf_read_en, rf_write_en, rf_write_data, clear_start, ram_rdata,
        output rf_read_data, rf_done, rf_access_err, clear_busy,
        output ram_wen, ram_ren, ram_addr, ram_wdata
    );

    // Requester / RAM side.
    modport master (
        output rf_address, rf_read_en, rf_write_en, rf_write_data, clear_start, ram_rdata,
        input  rf_read_data, rf_done, rf_access_err, clear_busy,
        input  ram_wen, ram_ren, ram_addr, ram_wdata
    );
endinterface

// File: rtl/ram_rf_port.sv
// Register-file access controller in front of a single-port synchronous RAM.
// Serves single-cycle read/write requests and a full zero-fill; all outputs are registered.
module ram_rf_port #(
    parameter int unsigned DATASIZE  = 18,
    parameter int unsigned ADDRSIZE  = 8,
    parameter int unsigned PIPELINED = 0
) (
    input  logic          clk,
    input  logic          res_n,
    ram_rf_port_if.slave  bus
);
    typedef enum logic [1:0] {StIdle, StReadWait, StClear} state_e;

    // READ_WAIT cycle index at which ram_rdata is valid.
    localparam logic [1:0]          WaitLast = 2'(PIPELINED + 1);
    localparam logic [ADDRSIZE-1:0] CntLast  = '1;

    state_e              state_q, state_d;
    logic [ADDRSIZE-1:0] cnt_q, cnt_d;
    logic [1:0]          wait_q, wait_d;
    logic                pend_q, pend_d;
    logic [DATASIZE-1:0] rd_data_q, rd_data_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                busy_q, busy_d;
    logic                wen_q, wen_d;
    logic                ren_q, ren_d;
    logic [ADDRSIZE-1:0] addr_q, addr_d;
    logic [DATASIZE-1:0] wdata_q, wdata_d;

    logic req;
    logic reject;
    logic slot_busy;

    // Next-state, RAM command and completion/rejection reporting.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wait_d    = wait_q;
        pend_d    = pend_q;
        rd_data_d = rd_data_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        busy_d    = 1'b0;
        wen_d     = 1'b0;
        ren_d     = 1'b0;
        req       = bus.rf_read_en | bus.rf_write_en;
        reject    = 1'b0;
        slot_busy = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.clear_start) begin
                    // Clear wins; a simultaneous request is rejected.
                    state_d = StClear;
                    wen_d   = 1'b1;
                    addr_d  = cnt_q;
                    wdata_d = '0;
                    busy_d  = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    reject  = req;
                end else if (bus.rf_write_en) begin
                    // Write wins over a simultaneous read, which is dropped silently.
                    wen_d     = 1'b1;
                    addr_d    = bus.rf_address;
                    wdata_d   = bus.rf_write_data;
                    done_d    = 1'b1;
                    slot_busy = 1'b1;
                end else if (bus.rf_read_en) begin
                    ren_d   = 1'b1;
                    addr_d  = bus.rf_address;
                    wait_d  = '0;
                    state_d = StReadWait;
                end
            end
            StReadWait: begin
                reject = req;
                if (wait_q == WaitLast) begin
                    rd_data_d = bus.ram_rdata;
                    done_d    = 1'b1;
                    slot_busy = 1'b1;
                    state_d   = StIdle;
                end else begin
                    wait_d = wait_q + 2'd1;
                end
            end
            StClear: begin
                reject  = req;
                wen_d   = 1'b1;
                addr_d  = cnt_q;
                wdata_d = '0;
                busy_d  = 1'b1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CntLast) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // One done slot per cycle: completions first, then the older queued rejection,
        // then a fresh one. Only one rejection is held; extras are dropped.
        if (slot_busy) begin
            pend_d = pend_q | reject;
        end else if (pend_q) begin
            done_d = 1'b1;
            err_d  = 1'b1;
            pend_d = reject;
        end else if (reject) begin
            done_d = 1'b1;
            err_d  = 1'b1;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            wait_q    <= '0;
            pend_q    <= 1'b0;
            rd_data_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            wen_q     <= 1'b0;
            ren_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wait_q    <= wait_d;
            pend_q    <= pend_d;
            rd_data_q <= rd_data_d;
            done_q    <= done_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            wen_q     <= wen_d;
            ren_q     <= ren_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
        end
    end

    assign bus.rf_read_data  = rd_data_q;
    assign bus.rf_done       = done_q;
    assign bus.rf_access_err = err_q;
    assign bus.clear_busy    = busy_q;
    assign bus.ram_wen       = wen_q;
    assign bus.ram_ren       = ren_q;
    assign bus.ram_addr      = addr_q;
    assign bus.ram_wdata     = wdata_q;
endmodule
